ks_share_ctrl: RTL and testbench
================================

# ks_share_ctrl

Two-channel scheduler that time-shares one Trivium-lite keystream update datapath between two independent requesters. Each channel keeps its own saved 24-bit cipher context (s1, s2, s3). The controller arbitrates round-robin, loads the granted context, runs 8 update steps to produce one keystream byte, and writes the context back. The XORed result goes into a single backpressured output register. It sits between the host-facing channel ports and the keystream engine, replacing the single-session IDLE/RUN/RESET sequencing.

## Interface
- WARMUP, 16: discard steps run after a seed load (0..255); only used when TRIVCTL_WARMUP_EN is defined.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ch0_valid / ch1_valid  in  1  request pending
- ch0_seed / ch1_seed  in  1  1 = seed-load request, 0 = data request
- ch0_data / ch1_data  in  8  seed byte or plaintext byte
- ch0_ready / ch1_ready  out  1  acceptance strobe; combinational, high only in IDLE for the granted channel
- out_valid  out  1  response held valid
- out_ready  in  1  consumer accepts response
- out_ch  out  1  channel the response belongs to
- out_data  out  8  data XOR keystream; 0x00 for seed acks and errors
- out_err  out  1  request rejected

## Operation
- **Seed mapping:** s1=seed; s2={~seed[3:0],seed[7:4]}; s3=seed^8'hA5. Seeds 0x00 and 0xFF are illegal: respond with out_err=1 and leave the context unchanged.
- **Step** (all right-hand sides use old values):
  - b=s1[0]^s2[0]^s3[0]
  - s1<={s1[6:0],s2[0]^s3[1]}
  - s2<={s2[6:0],s3[3]^s1[1]}
  - s3<={s3[6:0],s1[5]^s2[2]}
  - ks<={ks[6:0],b}
  - The first bit ends up in the MSB.
- **Per-channel flag** seeded[i] is cleared at reset. A data request on an unseeded channel gets out_err=1, out_data=0x00, and no steps run.
- **Arbitration:**
  - A single pointer rr (reset 0) names the preferred channel.
  - Grant goes to rr if its valid is set, otherwise to the other channel.
  - After each response is consumed, rr becomes the other channel of the one just served.
- **States:**
  - IDLE: grant. On valid&ready go to SEED or LOAD.
  - SEED: validate the seed and write the context. Go to WARM if the macro is defined and WARMUP>0, else RESP.
  - WARM: run WARMUP steps on the context, ks discarded, then RESP.
  - LOAD: copy the context into the working registers, clear ks, step counter=0.
  - RUN: 8 steps, then write the context back; out_data=data^ks; go to RESP.
  - RESP: hold out_* until out_ready, then IDLE.
- Request data/seed/ch are latched at acceptance; requester inputs may change afterwards.
- Only one request is in flight at a time. The other channel waits with valid held.

## Timing
- **Reset values:** out_valid=0, out_ch=0, out_data=0x00, out_err=0, chN_ready=0. Contexts=0, seeded=0, rr=0, state IDLE.
- **Data latency:** accept on edge T; LOAD at T+1; RUN steps on edges T+2..T+9; out_valid high from T+9.
- **Seed latency:** ack out_valid high from T+2. With warmup: T+2+WARMUP.
- **Response handshake:** the response completes on the edge where out_valid&out_ready. The next acceptance happens at the earliest one cycle later (IDLE cycle).
- **Backpressure:** out_ready low holds RESP indefinitely. chN_ready stays 0 during this time.
- **Both valid in IDLE:** only the rr channel gets ready.
- **Asynchronous reset mid-RUN:** the in-flight result is lost, all contexts are cleared, and both channels return to unseeded.

## Configuration
- TRIVCTL_WARMUP_EN:
  - Defined: seed loads run WARMUP discard steps before the ack.
  - Undefined: no warmup logic; the ack comes two cycles after acceptance; WARMUP is ignored.
- Test values below assume the macro is undefined.

## Test plan
- Reset released, no requests: all outputs 0, ch0_ready=1, ch1_ready=0.
- ch0 seed 0x01, then data 0x00: seed ack (err=0, data 0x00) at T+2. Data response out_data=0x82 at T+9. Saved ch0 context becomes s1=0x01, s2=0x00, s3=0x04.
- ch0 data 0x55 before any seed: out_err=1, out_data=0x00. ch0 seed 0xFF: out_err=1, and a following data request still errors.
- ch0 and ch1 both seeded 0x01, ch0 data 0x00 served first, then ch1 data 0xFF: ch1 out_data=0x7D, which shows context isolation.
- Both valid continuously: grants alternate 0,1,0,1 with matching out_ch. out_ready held low 5 cycles: out_* stable and no ready strobes.
- rst_n asserted during RUN: out_valid=0 immediately. After release, a data request on ch0 gets out_err=1.

Source files
------------

// File: rtl/ks_share_ctrl_if.sv
// Channel request ports and the shared response port of ks_share_ctrl.
// slave is the controller's view; master is the requester/consumer view.
interface ks_share_ctrl_if;
  logic       ch0_valid;
  logic       ch0_seed;
  logic [7:0] ch0_data;
  logic       ch0_ready;
  logic       ch1_valid;
  logic       ch1_seed;
  logic [7:0] ch1_data;
  logic       ch1_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_ch;
  logic [7:0] out_data;
  logic       out_err;

  modport slave (
    input  ch0_valid, ch0_seed, ch0_data, ch1_valid, ch1_seed, ch1_data, out_ready,
    output ch0_ready, ch1_ready, out_valid, out_ch, out_data, out_err
  );

  modport master (
    output ch0_valid, ch0_seed, ch0_data, ch1_valid, ch1_seed, ch1_data, out_ready,
    input  ch0_ready, ch1_ready, out_valid, out_ch, out_data, out_err
  );
endinterface

// File: rtl/ks_share_ctrl.sv
// ks_share_ctrl: round-robin time-sharing of one Trivium-lite keystream
// datapath between two channels, each with its own saved 24-bit context.
// Optional feature macro TRIVCTL_WARMUP_EN: seed loads run WARMUP discard
// steps before the ack. Without it there is no warmup logic at all.
module ks_share_ctrl
`ifdef TRIVCTL_WARMUP_EN
  #(parameter int unsigned WARMUP = 16)
`endif
(
  input logic            clk,
  input logic            rst_n,
  ks_share_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_WARM = 3'd2,
    S_LOAD = 3'd3,
    S_RUN  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      state_r, state_nx_s;
  logic        rr_r, ch_r, seed_req_r, err_r;
  logic [7:0]  data_r;
  logic [7:0]  s1_r, s2_r, s3_r, ks_r;
  logic [2:0]  cnt_r;
  logic [7:0]  ctx_s1_r [2];
  logic [7:0]  ctx_s2_r [2];
  logic [7:0]  ctx_s3_r [2];
  logic [1:0]  seeded_r;
  logic        out_valid_r, out_ch_r, out_err_r;
  logic [7:0]  out_data_r;
  logic [1:0]  req_valid_s, ready_s;
  logic        grant_s, accept_s, req_seed_s, seed_ok_s;
  logic [7:0]  req_data_s;
  logic [31:0] step_s;
  logic [23:0] seed_ctx_s;
`ifdef TRIVCTL_WARMUP_EN
  localparam logic [7:0] WarmLast = 8'(WARMUP - 1);
  logic [7:0] warm_cnt_r;
`endif

  // One datapath update: returns {s1, s2, s3, ks}, new keystream bit in ks LSB.
  function automatic logic [31:0] ks_step(input logic [7:0] s1, input logic [7:0] s2,
                                          input logic [7:0] s3, input logic [7:0] ks);
    logic b;
    b = s1[0] ^ s2[0] ^ s3[0];
    return {s1[6:0], s2[0] ^ s3[1], s2[6:0], s3[3] ^ s1[1],
            s3[6:0], s1[5] ^ s2[2], ks[6:0], b};
  endfunction

  // Seed byte to initial {s1, s2, s3} context.
  function automatic logic [23:0] seed_map(input logic [7:0] seed);
    return {seed, ~seed[3:0], seed[7:4], seed ^ 8'hA5};
  endfunction

  // Grant selection, ready strobes and the step/seed helpers.
  always_comb begin
    req_valid_s = {bus.ch1_valid, bus.ch0_valid};
    if (!req_valid_s[rr_r] && req_valid_s[~rr_r]) begin
      grant_s = ~rr_r;
    end else begin
      grant_s = rr_r;
    end
    ready_s = 2'b00;
    if (rst_n && (state_r == S_IDLE)) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = 2'b00;
    end
    accept_s   = req_valid_s[grant_s] & ready_s[grant_s];
    req_seed_s = grant_s ? bus.ch1_seed : bus.ch0_seed;
    req_data_s = grant_s ? bus.ch1_data : bus.ch0_data;
    seed_ok_s  = (data_r != 8'h00) && (data_r != 8'hFF);
    step_s     = ks_step(s1_r, s2_r, s3_r, ks_r);
    seed_ctx_s = seed_map(data_r);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx_s = req_seed_s ? S_SEED : S_LOAD;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_SEED: begin
`ifdef TRIVCTL_WARMUP_EN
        if (seed_ok_s && (WARMUP > 0)) begin
          state_nx_s = S_WARM;
        end else begin
          state_nx_s = S_RESP;
        end
`else
        state_nx_s = S_RESP;
`endif
      end
`ifdef TRIVCTL_WARMUP_EN
      S_WARM: begin
        if (warm_cnt_r == WarmLast) begin
          state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_WARM;
        end
      end
`endif
      S_LOAD: begin
        if (seeded_r[ch_r]) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_RESP;
        end
      end
      S_RUN: begin
        if (cnt_r == 3'd7) begin
          state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_RESP: begin
        if (out_valid_r && bus.out_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Request latch, context store, working datapath and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r <= 1'b0; ch_r <= 1'b0; seed_req_r <= 1'b0; err_r <= 1'b0;
      data_r <= 8'h00; s1_r <= 8'h00; s2_r <= 8'h00; s3_r <= 8'h00; ks_r <= 8'h00;
      cnt_r <= 3'd0; seeded_r <= 2'b00;
      ctx_s1_r[0] <= 8'h00; ctx_s2_r[0] <= 8'h00; ctx_s3_r[0] <= 8'h00;
      ctx_s1_r[1] <= 8'h00; ctx_s2_r[1] <= 8'h00; ctx_s3_r[1] <= 8'h00;
      out_valid_r <= 1'b0; out_ch_r <= 1'b0; out_err_r <= 1'b0; out_data_r <= 8'h00;
`ifdef TRIVCTL_WARMUP_EN
      warm_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            ch_r       <= grant_s;
            seed_req_r <= req_seed_s;
            data_r     <= req_data_s;
          end
        end
        S_SEED: begin
          // Illegal seeds leave the saved context and seeded flag untouched.
          err_r <= ~seed_ok_s;
          if (seed_ok_s) begin
            ctx_s1_r[ch_r] <= seed_ctx_s[23:16];
            ctx_s2_r[ch_r] <= seed_ctx_s[15:8];
            ctx_s3_r[ch_r] <= seed_ctx_s[7:0];
            seeded_r[ch_r] <= 1'b1;
            s1_r <= seed_ctx_s[23:16];
            s2_r <= seed_ctx_s[15:8];
            s3_r <= seed_ctx_s[7:0];
          end
`ifdef TRIVCTL_WARMUP_EN
          warm_cnt_r <= 8'd0;
`endif
        end
`ifdef TRIVCTL_WARMUP_EN
        S_WARM: begin
          s1_r <= step_s[31:24]; s2_r <= step_s[23:16]; s3_r <= step_s[15:8];
          warm_cnt_r <= warm_cnt_r + 8'd1;
          if (warm_cnt_r == WarmLast) begin
            ctx_s1_r[ch_r] <= step_s[31:24];
            ctx_s2_r[ch_r] <= step_s[23:16];
            ctx_s3_r[ch_r] <= step_s[15:8];
          end
        end
`endif
        S_LOAD: begin
          s1_r  <= ctx_s1_r[ch_r];
          s2_r  <= ctx_s2_r[ch_r];
          s3_r  <= ctx_s3_r[ch_r];
          ks_r  <= 8'h00;
          cnt_r <= 3'd0;
          err_r <= ~seeded_r[ch_r];
        end
        S_RUN: begin
          {s1_r, s2_r, s3_r, ks_r} <= step_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            // Last step: save context and raise the response on the same edge.
            ctx_s1_r[ch_r] <= step_s[31:24];
            ctx_s2_r[ch_r] <= step_s[23:16];
            ctx_s3_r[ch_r] <= step_s[15:8];
            out_valid_r    <= 1'b1;
            out_ch_r       <= ch_r;
            out_err_r      <= 1'b0;
            out_data_r     <= data_r ^ step_s[7:0];
          end
        end
        S_RESP: begin
          if (!out_valid_r) begin
            // Seed acks and error responses carry no data.
            out_valid_r <= 1'b1;
            out_ch_r    <= ch_r;
            out_err_r   <= err_r;
            out_data_r  <= 8'h00;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            rr_r        <= ~out_ch_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch0_ready = ready_s[0];
  assign bus.ch1_ready = ready_s[1];
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_ks_share_ctrl.sv
// Randomized self-checking bench for ks_share_ctrl against a behavioural
// model of the channel contexts, seed rules and round-robin pointer.
module tb_ks_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ks_share_ctrl_if bus ();

  ks_share_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model state
  logic [7:0] m_s1 [2];
  logic [7:0] m_s2 [2];
  logic [7:0] m_s3 [2];
  bit         m_seeded [2];
  bit         m_rr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 8'h00; m_s2[i] = 8'h00; m_s3[i] = 8'h00; m_seeded[i] = 1'b0;
    end
    m_rr = 1'b0;
  endtask

  // Expected response of one request, updating the model contexts.
  task automatic model_req(input bit ch, input bit sd, input logic [7:0] d,
                           output bit e_err, output logic [7:0] e_data);
    logic [7:0] a, b, c, k;
    bit bt, n1, n2, n3;
    e_data = 8'h00;
    if (sd) begin
      if (d == 8'h00 || d == 8'hFF) begin
        e_err = 1'b1;
      end else begin
        e_err = 1'b0;
        m_s1[ch] = d;
        m_s2[ch] = 8'(((~d) & 8'h0F) << 4) | (d >> 4);
        m_s3[ch] = d ^ 8'hA5;
        m_seeded[ch] = 1'b1;
      end
    end else if (!m_seeded[ch]) begin
      e_err = 1'b1;
    end else begin
      e_err = 1'b0;
      a = m_s1[ch]; b = m_s2[ch]; c = m_s3[ch]; k = 8'h00;
      for (int i = 0; i < 8; i++) begin
        bt = a[0] ^ b[0] ^ c[0];
        n1 = b[0] ^ c[1];
        n2 = c[3] ^ a[1];
        n3 = a[5] ^ b[2];
        a = 8'(a << 1) | {7'd0, n1};
        b = 8'(b << 1) | {7'd0, n2};
        c = 8'(c << 1) | {7'd0, n3};
        k[7 - i] = bt;
      end
      m_s1[ch] = a; m_s2[ch] = b; m_s3[ch] = c;
      e_data = d ^ k;
    end
  endtask

  function automatic bit rdy(input bit ch);
    return ch ? bus.ch1_ready : bus.ch0_ready;
  endfunction

  task automatic drive(input bit ch, input bit v, input bit sd, input logic [7:0] d);
    if (ch) begin
      bus.ch1_valid = v; bus.ch1_seed = sd; bus.ch1_data = d;
    end else begin
      bus.ch0_valid = v; bus.ch0_seed = sd; bus.ch0_data = d;
    end
  endtask

  // Wait for out_valid (at most 40 cycles), return the cycles waited.
  task automatic wait_resp(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("resp_timeout", bus.out_valid, 1'b1);
  endtask

  // Check the held response, apply backpressure for hold cycles, then consume.
  task automatic check_and_consume(input string tag, input bit ch, input bit e_err,
                                   input logic [7:0] e_data, input int hold);
    check_eq({tag, "_ch"}, bus.out_ch, ch);
    check_eq({tag, "_err"}, bus.out_err, e_err);
    check_eq({tag, "_data"}, bus.out_data, e_data);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      check_eq({tag, "_hold_data"}, {bus.out_ch, bus.out_err, bus.out_data}, {ch, e_err, e_data});
      check_eq({tag, "_hold_ready"}, {bus.ch1_ready, bus.ch0_ready}, 2'b00);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_consumed"}, bus.out_valid, 1'b0);
    m_rr = ~ch;
  endtask

  // Accept one request on a channel (only that channel valid).
  task automatic accept(input bit ch, input bit sd, input logic [7:0] d, output bit ok);
    @(negedge clk);
    drive(ch, 1'b1, sd, d);
    #1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rdy(ch)) ok = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check_eq("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    // Requester inputs are free to change after acceptance.
    drive(ch, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic run_req(input string tag, input bit ch, input bit sd,
                         input logic [7:0] d, input int hold);
    bit e_err, ok;
    logic [7:0] e_data;
    int n;
    model_req(ch, sd, d, e_err, e_data);
    accept(ch, sd, d, ok);
    if (ok) begin
      wait_resp(n);
      if (sd) check_eq({tag, "_seed_lat"}, n, 2);
      else if (!e_err) check_eq({tag, "_data_lat"}, n, 9);
      if (bus.out_valid) check_and_consume(tag, ch, e_err, e_data, hold);
    end
  endtask

  // Both channels hold data requests; grants must follow the model pointer.
  task automatic arb_run(input int cnt);
    bit g, e_err, ok;
    logic [7:0] d, e_data;
    int n;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0, 8'($urandom));
    for (int k = 0; k < cnt; k++) begin
      #1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        if (bus.ch0_ready || bus.ch1_ready) ok = 1'b1;
        else begin @(negedge clk); #1; end
      end
      check_eq("arb_ready_timeout", ok, 1'b1);
      check_eq("arb_grant", {bus.ch1_ready, bus.ch0_ready}, m_rr ? 2'b10 : 2'b01);
      g = m_rr;
      d = g ? bus.ch1_data : bus.ch0_data;
      model_req(g, 1'b0, d, e_err, e_data);
      @(posedge clk); #1;
      drive(g, 1'b1, 1'b0, 8'($urandom));
      wait_resp(n);
      check_eq("arb_lat", n, 9);
      check_and_consume("arb", g, e_err, e_data, (k == 0) ? 5 : 0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, ch, sd;
    logic [7:0] d;
    int r;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("in_reset_ready", {bus.ch1_ready, bus.ch0_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rst_out", {bus.out_valid, bus.out_ch, bus.out_err, bus.out_data}, 11'd0);
    check_eq("rst_ready", {bus.ch1_ready, bus.ch0_ready}, 2'b01);

    // Directed cases
    run_req("unseeded", 1'b0, 1'b0, 8'h55, 0);
    run_req("seed_ff", 1'b0, 1'b1, 8'hFF, 0);
    run_req("after_ff", 1'b0, 1'b0, 8'h12, 0);
    run_req("seed_00", 1'b0, 1'b1, 8'h00, 0);
    run_req("seed01_c0", 1'b0, 1'b1, 8'h01, 0);
    run_req("data00_c0", 1'b0, 1'b0, 8'h00, 1);
    run_req("seed01_c1", 1'b1, 1'b1, 8'h01, 0);
    run_req("dataff_c1", 1'b1, 1'b0, 8'hFF, 2);

    // Round-robin with both channels pending
    arb_run(4);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      ch = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      d = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      run_req("rand", ch, sd, d, $urandom_range(0, 2));
    end
    arb_run(3);

    // Reset while a data request is running
    run_req("pre_rst_seed", 1'b0, 1'b1, 8'h3C, 0);
    accept(1'b0, 1'b0, 8'hA7, ok);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_eq("midrun_valid", bus.out_valid, 1'b0);
    check_eq("midrun_ready", {bus.ch1_ready, bus.ch0_ready}, 2'b00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_valid", bus.out_valid, 1'b0);
    run_req("post_rst_c0", 1'b0, 1'b0, 8'h5A, 0);
    run_req("post_rst_c1", 1'b1, 1'b0, 8'hC3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
